exe_mem_stage: RTL and testbench

EXE_MEM_STAGE -- requirements
Module: exe_mem_stage

---
 rtl/exe_mem_if.sv | 49 ++++
 rtl/exe_mem_stage.sv | 86 ++++++++
 tb/tb_exe_mem_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/exe_mem_if.sv
// EXE->MEM pipeline register bundle: EXE-side fields, controls,
// and the registered MEM-side fields with status and retire count.
interface exe_mem_if;
    logic        freeze;
    logic        flush;
    logic        valid_in;
    logic [31:0] alu_res_in;
    logic        n_in;
    logic        z_in;
    logic        c_in;
    logic        v_in;
    logic        s_in;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [3:0]  dest_in;
    logic [31:0] val_rm_in;

    logic [3:0]  status_out;
    logic        c_status;
    logic        valid_out;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic        mem_w_en_out;
    logic [31:0] alu_res_out;
    logic [3:0]  dest_out;
    logic [31:0] val_rm_out;
    logic [31:0] retire_cnt;

    modport master (
        output freeze, flush, valid_in, alu_res_in,
        output n_in, z_in, c_in, v_in, s_in,
        output wb_en_in, mem_r_en_in, mem_w_en_in,
        output dest_in, val_rm_in,
        input  status_out, c_status, valid_out,
        input  wb_en_out, mem_r_en_out, mem_w_en_out,
        input  alu_res_out, dest_out, val_rm_out, retire_cnt
    );

    modport slave (
        input  freeze, flush, valid_in, alu_res_in,
        input  n_in, z_in, c_in, v_in, s_in,
        input  wb_en_in, mem_r_en_in, mem_w_en_in,
        input  dest_in, val_rm_in,
        output status_out, c_status, valid_out,
        output wb_en_out, mem_r_en_out, mem_w_en_out,
        output alu_res_out, dest_out, val_rm_out, retire_cnt
    );
endinterface

// File: rtl/exe_mem_stage.sv
// EXE->MEM pipeline register with status-flag register and retire counter.
// Freeze holds everything; flush or an invalid slot loads a bubble.
module exe_mem_stage (
    input  logic       clk,
    input  logic       rst,
    exe_mem_if.slave   io
);
    logic        accept;
    logic        rd_win;
    logic        st_only;

    logic        valid_d, valid_q;
    logic        wb_d, wb_q;
    logic        mr_d, mr_q;
    logic        mw_d, mw_q;
    logic [31:0] alu_d, alu_q;
    logic [3:0]  dest_d, dest_q;
    logic [31:0] rm_d, rm_q;
    logic [3:0]  stat_d, stat_q;
    logic [31:0] cnt_q, cnt_d;

    assign accept  = io.valid_in & ~io.flush & ~io.freeze;
    assign rd_win  = io.mem_r_en_in;
    // A simultaneous read+write request is resolved as a read.
    assign st_only = io.mem_w_en_in & ~rd_win;

    always_comb begin
        valid_d = valid_q;
        wb_d    = wb_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        alu_d   = alu_q;
        dest_d  = dest_q;
        rm_d    = rm_q;
        stat_d  = stat_q;
        cnt_d   = cnt_q;
        if (!io.freeze) begin
            valid_d = accept;
            wb_d    = accept & io.wb_en_in & ~st_only;
            mr_d    = accept & rd_win;
            mw_d    = accept & st_only;
            alu_d   = accept ? io.alu_res_in : 32'h0;
            dest_d  = accept ? io.dest_in : 4'h0;
            rm_d    = accept ? io.val_rm_in : 32'h0;
            if (accept && io.s_in)
                stat_d = {io.n_in, io.z_in, io.c_in, io.v_in};
            if (accept)
                cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            wb_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            alu_q   <= 32'h0;
            dest_q  <= 4'h0;
            rm_q    <= 32'h0;
            stat_q  <= 4'h0;
            cnt_q   <= 32'h0;
        end else begin
            valid_q <= valid_d;
            wb_q    <= wb_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            alu_q   <= alu_d;
            dest_q  <= dest_d;
            rm_q    <= rm_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign io.valid_out    = valid_q;
    assign io.wb_en_out    = wb_q;
    assign io.mem_r_en_out = mr_q;
    assign io.mem_w_en_out = mw_q;
    assign io.alu_res_out  = alu_q;
    assign io.dest_out     = dest_q;
    assign io.val_rm_out   = rm_q;
    assign io.status_out   = stat_q;
    assign io.c_status     = stat_q[1];
    assign io.retire_cnt   = cnt_q;
endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed bench for exe_mem_stage: load, status gating, flush,
// freeze, counter wrap, read/write priority and async reset.
module tb_exe_mem_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exe_mem_if bus ();

    exe_mem_stage dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu,
                         input logic [3:0] dst, input logic [31:0] rm,
                         input logic s, input logic [3:0] fl,
                         input logic wb, input logic mr, input logic mw);
        bus.valid_in    = v;
        bus.alu_res_in  = alu;
        bus.dest_in     = dst;
        bus.val_rm_in   = rm;
        bus.s_in        = s;
        {bus.n_in, bus.z_in, bus.c_in, bus.v_in} = fl;
        bus.wb_en_in    = wb;
        bus.mem_r_en_in = mr;
        bus.mem_w_en_in = mw;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 32'(bus.valid_out), 32'h0);
        chk({tag, ".wb"}, 32'(bus.wb_en_out), 32'h0);
        chk({tag, ".mr"}, 32'(bus.mem_r_en_out), 32'h0);
        chk({tag, ".mw"}, 32'(bus.mem_w_en_out), 32'h0);
        chk({tag, ".alu"}, bus.alu_res_out, 32'h0);
        chk({tag, ".dest"}, 32'(bus.dest_out), 32'h0);
        chk({tag, ".rm"}, bus.val_rm_out, 32'h0);
        chk({tag, ".stat"}, 32'(bus.status_out), 32'h0);
        chk({tag, ".cst"}, 32'(bus.c_status), 32'h0);
        chk({tag, ".cnt"}, bus.retire_cnt, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.freeze = 1'b0;
        bus.flush  = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 4'hF, 32'h1234, 1'b1, 4'hF,
              1'b1, 1'b1, 1'b1);
        tick();
        tick();
        chk_zero("reset");

        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 32'h10, 4'h3, 32'hAA, 1'b1, 4'b0010,
              1'b1, 1'b0, 1'b0);
        tick();
        chk("acc.alu", bus.alu_res_out, 32'h10);
        chk("acc.dest", 32'(bus.dest_out), 32'h3);
        chk("acc.valid", 32'(bus.valid_out), 32'h1);
        chk("acc.wb", 32'(bus.wb_en_out), 32'h1);
        chk("acc.rm", bus.val_rm_out, 32'hAA);
        chk("acc.stat", 32'(bus.status_out), 32'h2);
        chk("acc.cst", 32'(bus.c_status), 32'h1);
        chk("acc.cnt", bus.retire_cnt, 32'h1);

        drive(1'b1, 32'h20, 4'h5, 32'hBB, 1'b0, 4'b1111,
              1'b1, 1'b0, 1'b0);
        tick();
        chk("nos.alu", bus.alu_res_out, 32'h20);
        chk("nos.dest", 32'(bus.dest_out), 32'h5);
        chk("nos.stat", 32'(bus.status_out), 32'h2);
        chk("nos.cnt", bus.retire_cnt, 32'h2);

        bus.flush = 1'b1;
        drive(1'b1, 32'h30, 4'h6, 32'hCC, 1'b1, 4'b0100,
              1'b1, 1'b1, 1'b0);
        tick();
        chk("fl.valid", 32'(bus.valid_out), 32'h0);
        chk("fl.wb", 32'(bus.wb_en_out), 32'h0);
        chk("fl.mr", 32'(bus.mem_r_en_out), 32'h0);
        chk("fl.alu", bus.alu_res_out, 32'h0);
        chk("fl.stat", 32'(bus.status_out), 32'h2);
        chk("fl.cnt", bus.retire_cnt, 32'h2);

        bus.flush = 1'b0;
        drive(1'b1, 32'h44, 4'h7, 32'hDD, 1'b0, 4'b0000,
              1'b1, 1'b0, 1'b1);
        tick();
        chk("st.mw", 32'(bus.mem_w_en_out), 32'h1);
        chk("st.wb", 32'(bus.wb_en_out), 32'h0);
        chk("st.cnt", bus.retire_cnt, 32'h3);

        bus.freeze = 1'b1;
        bus.flush  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'(i), 32'h100 + 32'(i), 4'(i), 32'(i), 1'b1, 4'(i + 8),
                  1'b1, 1'b1, 1'b0);
            tick();
            chk("frz.alu", bus.alu_res_out, 32'h44);
            chk("frz.mw", 32'(bus.mem_w_en_out), 32'h1);
            chk("frz.valid", 32'(bus.valid_out), 32'h1);
            chk("frz.stat", 32'(bus.status_out), 32'h2);
            chk("frz.cnt", bus.retire_cnt, 32'h3);
        end

        bus.freeze = 1'b0;
        bus.flush  = 1'b0;
        drive(1'b1, 32'h55, 4'h9, 32'hEE, 1'b1, 4'b1000,
              1'b1, 1'b0, 1'b0);
        tick();
        chk("unf.alu", bus.alu_res_out, 32'h55);
        chk("unf.dest", 32'(bus.dest_out), 32'h9);
        chk("unf.mw", 32'(bus.mem_w_en_out), 32'h0);
        chk("unf.stat", 32'(bus.status_out), 32'h8);
        chk("unf.cst", 32'(bus.c_status), 32'h0);
        chk("unf.cnt", bus.retire_cnt, 32'h4);

        drive(1'b0, 32'h66, 4'hA, 32'hFF, 1'b1, 4'b0110,
              1'b1, 1'b1, 1'b1);
        tick();
        chk("bub.valid", 32'(bus.valid_out), 32'h0);
        chk("bub.alu", bus.alu_res_out, 32'h0);
        chk("bub.stat", 32'(bus.status_out), 32'h8);
        chk("bub.cnt", bus.retire_cnt, 32'h4);

        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        #1;
        chk("wrap.pre", bus.retire_cnt, 32'hFFFF_FFFF);
        drive(1'b1, 32'h77, 4'hB, 32'h11, 1'b0, 4'b0000,
              1'b1, 1'b1, 1'b1);
        tick();
        chk("wrap.cnt", bus.retire_cnt, 32'h0);
        chk("rw.mr", 32'(bus.mem_r_en_out), 32'h1);
        chk("rw.mw", 32'(bus.mem_w_en_out), 32'h0);
        chk("rw.wb", 32'(bus.wb_en_out), 32'h1);

        drive(1'b1, 32'h88, 4'hC, 32'h22, 1'b1, 4'b0111,
              1'b1, 1'b0, 1'b0);
        tick();
        chk("pre.alu", bus.alu_res_out, 32'h88);
        bus.freeze = 1'b1;
        bus.flush  = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk_zero("arst");
        tick();
        chk_zero("arst.hold");

        @(negedge clk);
        rst = 1'b1;
        bus.freeze = 1'b0;
        bus.flush  = 1'b0;
        drive(1'b1, 32'h99, 4'h1, 32'h33, 1'b1, 4'b0001,
              1'b0, 1'b0, 1'b0);
        tick();
        chk("post.alu", bus.alu_res_out, 32'h99);
        chk("post.stat", 32'(bus.status_out), 32'h1);
        chk("post.cnt", bus.retire_cnt, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
